// File: rtl/shift_deser_pkg.sv
// Shared types and framing constants for the framed serial receiver.
package shift_deser_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage : shift_deser_pkg

// File: rtl/deser_shift_reg.sv
// Data shift register: one bit per enable, direction chosen by LSB_FIRST.
module deser_shift_reg #(
   parameter int unsigned DATA_W    = 8,
   parameter bit          LSB_FIRST = 1'b0
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              shift_en,
   input  logic              serial_in,
   output logic [DATA_W-1:0] q
);

   // Shift toward LSB (first bit ends in q[0]) or toward MSB (first bit ends in q[DATA_W-1]).
   always_ff @(posedge clk) begin
      if (clear) begin
         q <= '0;
      end else if (shift_en) begin
         if (LSB_FIRST) begin
            q <= {serial_in, q[DATA_W-1:1]};
         end else begin
            q <= {q[DATA_W-2:0], serial_in};
         end
      end
   end

endmodule : deser_shift_reg

// File: rtl/shift_deser_rx.sv
// Framed serial-to-parallel receiver with valid/ready output.
// Frame: start(0), DATA_W data bits, optional parity, stop(1); one bit per bit_tick.
// Optional parity stage is compiled in with macro SHIFT_DESER_PARITY_EN.
module shift_deser_rx
   import shift_deser_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter bit          LSB_FIRST  = 1'b0,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              serial_in,
   input  logic              bit_tick,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              frame_err,
   output logic              parity_err,
   output logic              overrun,
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(DATA_W + 1);

   state_t             state;
   logic [CNT_W-1:0]   bit_cnt;
   logic [DATA_W-1:0]  shift_q;

   logic start_c;
   logic stop_tick_c;
   logic word_ok_c;
   logic last_data_c;

`ifdef SHIFT_DESER_PARITY_EN
   logic par_acc;
   logic par_bad;
`else
   logic unused_parity_odd;
   assign unused_parity_odd = PARITY_ODD;
`endif

   assign start_c     = bit_tick && (state == IDLE) && (serial_in == START_BIT);
   assign stop_tick_c = bit_tick && (state == STOP);
   assign last_data_c = (bit_cnt == CNT_W'(DATA_W - 1));
`ifdef SHIFT_DESER_PARITY_EN
   assign word_ok_c   = stop_tick_c && (serial_in == STOP_BIT) && !par_bad;
`else
   assign word_ok_c   = stop_tick_c && (serial_in == STOP_BIT);
`endif

   deser_shift_reg #(
      .DATA_W    (DATA_W),
      .LSB_FIRST (LSB_FIRST)
   ) u_shift (
      .clk       (clk),
      .clear     (reset || start_c),
      .shift_en  (bit_tick && (state == DATA)),
      .serial_in (serial_in),
      .q         (shift_q)
   );

   // Frame sequencer: advances only on bit_tick, busy tracks the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         bit_cnt <= '0;
         busy    <= 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
         par_acc <= 1'b0;
         par_bad <= 1'b0;
`endif
      end else if (bit_tick) begin
         case (state)
            IDLE: begin
               if (serial_in == START_BIT) begin
                  state   <= DATA;
                  bit_cnt <= '0;
                  busy    <= 1'b1;
`ifdef SHIFT_DESER_PARITY_EN
                  par_acc <= 1'b0;
                  par_bad <= 1'b0;
`endif
               end
            end
            DATA: begin
               bit_cnt <= bit_cnt + CNT_W'(1);
`ifdef SHIFT_DESER_PARITY_EN
               par_acc <= par_acc ^ serial_in;
               if (last_data_c) state <= PARITY;
`else
               if (last_data_c) state <= STOP;
`endif
            end
`ifdef SHIFT_DESER_PARITY_EN
            PARITY: begin
               par_bad <= (serial_in != (par_acc ^ PARITY_ODD));
               state   <= STOP;
            end
`endif
            STOP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Output word register, handshake and one-cycle status pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         frame_err <= stop_tick_c && (serial_in != STOP_BIT);
         overrun   <= 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
         parity_err <= stop_tick_c && par_bad;
`endif
         if (word_ok_c) begin
            if (!out_valid || out_ready) begin
               out_data  <= shift_q;
               out_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifndef SHIFT_DESER_PARITY_EN
   assign parity_err = 1'b0;
`endif

endmodule : shift_deser_rx

// File: tb/tb_shift_deser_rx.sv
// Bench for shift_deser_rx: frame-level bit-queue model plus directed frames.
module tb_shift_deser_rx;

   localparam int unsigned W = 8;
`ifdef SHIFT_DESER_PARITY_EN
   localparam int unsigned FRAME_LEN = W + 3;
   localparam bit          PAR_EN    = 1'b1;
`else
   localparam int unsigned FRAME_LEN = W + 2;
   localparam bit          PAR_EN    = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset, serial_in, bit_tick, out_ready;

   logic [W-1:0] m_out_data, l_out_data;
   logic m_out_valid, m_frame_err, m_parity_err, m_overrun, m_busy;
   logic l_out_valid, l_frame_err, l_parity_err, l_overrun, l_busy;

   always #5 clk = ~clk;

   shift_deser_rx #(.DATA_W(W), .LSB_FIRST(1'b0), .PARITY_ODD(1'b0)) dut_m (
      .clk(clk), .reset(reset), .serial_in(serial_in), .bit_tick(bit_tick),
      .out_data(m_out_data), .out_valid(m_out_valid), .out_ready(out_ready),
      .frame_err(m_frame_err), .parity_err(m_parity_err), .overrun(m_overrun), .busy(m_busy));

   shift_deser_rx #(.DATA_W(W), .LSB_FIRST(1'b1), .PARITY_ODD(1'b0)) dut_l (
      .clk(clk), .reset(reset), .serial_in(serial_in), .bit_tick(bit_tick),
      .out_data(l_out_data), .out_valid(l_out_valid), .out_ready(out_ready),
      .frame_err(l_frame_err), .parity_err(l_parity_err), .overrun(l_overrun), .busy(l_busy));

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h at t=%0t", name, got, exp, $time);
      end
   endtask

   // Model: collect ticked bits of a frame into a queue, judge the frame when it is complete.
   bit           rx_q[$];
   logic [W-1:0] e_data_m, e_data_l;
   logic         e_valid, e_ferr, e_perr, e_ovr, e_busy;

   always @(posedge clk) begin
      if (reset) begin
         rx_q.delete();
         e_data_m = '0; e_data_l = '0;
         e_valid = 1'b0; e_ferr = 1'b0; e_perr = 1'b0; e_ovr = 1'b0; e_busy = 1'b0;
      end else begin : model
         logic         commit, par, pbad;
         logic [W-1:0] wm, wl;
         e_ferr = 1'b0; e_perr = 1'b0; e_ovr = 1'b0; commit = 1'b0;
         wm = '0; wl = '0; par = 1'b0; pbad = 1'b0;
         if (bit_tick && !(rx_q.size() == 0 && serial_in == 1'b1))
            rx_q.push_back(serial_in);
         if (rx_q.size() == FRAME_LEN) begin
            for (int i = 0; i < W; i++) begin
               wm[W-1-i] = rx_q[1+i];
               wl[i]     = rx_q[1+i];
               par       = par ^ rx_q[1+i];
            end
            pbad   = PAR_EN && (rx_q[W+1] != par);
            e_ferr = (rx_q[FRAME_LEN-1] == 1'b0);
            e_perr = pbad;
            commit = !e_ferr && !pbad;
            rx_q.delete();
         end
         if (commit) begin
            if (!e_valid || out_ready) begin
               e_data_m = wm; e_data_l = wl; e_valid = 1'b1;
            end else begin
               e_ovr = 1'b1;
            end
         end else if (e_valid && out_ready) begin
            e_valid = 1'b0;
         end
         e_busy = (rx_q.size() != 0);
      end
   end

   // Every-cycle comparison of both DUTs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("m_data",   32'(m_out_data),   32'(e_data_m));
         check("m_valid",  32'(m_out_valid),  32'(e_valid));
         check("m_ferr",   32'(m_frame_err),  32'(e_ferr));
         check("m_perr",   32'(m_parity_err), 32'(e_perr));
         check("m_ovr",    32'(m_overrun),    32'(e_ovr));
         check("m_busy",   32'(m_busy),       32'(e_busy));
         check("l_data",   32'(l_out_data),   32'(e_data_l));
         check("l_valid",  32'(l_out_valid),  32'(e_valid));
         check("l_ferr",   32'(l_frame_err),  32'(e_ferr));
         check("l_ovr",    32'(l_overrun),    32'(e_ovr));
         check("l_busy",   32'(l_busy),       32'(e_busy));
      end
   end

   task automatic tick(input logic b, input int gap);
      serial_in = b;
      bit_tick  = 1'b1;
      @(posedge clk); #1;
      bit_tick  = 1'b0;
      serial_in = 1'b1;
      repeat (gap) begin
         @(posedge clk); #1;
      end
   endtask

   // Sends one frame; the stop tick is the last edge, so the next negedge shows its result.
   task automatic send_frame(input logic [W-1:0] w, input logic stop, input logic flip_par,
                             input int gap, input logic rdy_stop);
      logic saved;
      tick(1'b0, gap);
      for (int i = 0; i < W; i++) tick(w[W-1-i], gap);
      if (PAR_EN) tick((^w) ^ flip_par, gap);
      saved     = out_ready;
      out_ready = saved | rdy_stop;
      tick(stop, 0);
      out_ready = saved;
   endtask

   initial begin
      reset = 1'b1; serial_in = 1'b1; bit_tick = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(m_out_valid), 32'd0);
      check("rst_data",  32'(m_out_data),  32'd0);
      check("rst_busy",  32'(m_busy),      32'd0);
      @(posedge clk); #1;
      reset  = 1'b0;
      chk_en = 1'b1;
      repeat (2) @(posedge clk); #1;

      // Basic frame, both bit orders.
      send_frame(8'hA6, 1'b1, 1'b0, 1, 1'b0);
      @(negedge clk);
      check("a6_msb",   32'(m_out_data),  32'h0000_00A6);
      check("a6_lsb",   32'(l_out_data),  32'h0000_0065);
      check("a6_valid", 32'(m_out_valid), 32'd1);
      check("a6_ferr",  32'(m_frame_err), 32'd0);
      @(posedge clk); #1;

      // Second good frame while A6 is still held.
      send_frame(8'h3C, 1'b1, 1'b0, 1, 1'b0);
      @(negedge clk);
      check("ovr_pulse", 32'(m_overrun),  32'd1);
      check("ovr_keep",  32'(m_out_data), 32'h0000_00A6);
      @(posedge clk); #1;

      // Consumer ready in the stop-tick cycle: replace the held word.
      send_frame(8'h3C, 1'b1, 1'b0, 1, 1'b1);
      @(negedge clk);
      check("rdy_data",  32'(m_out_data),  32'h0000_003C);
      check("rdy_valid", 32'(m_out_valid), 32'd1);
      check("rdy_ovr",   32'(m_overrun),   32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("drain_valid", 32'(m_out_valid), 32'd0);
      check("drain_data",  32'(m_out_data),  32'h0000_003C);
      @(posedge clk); #1;

      // Bad stop bit.
      send_frame(8'hA6, 1'b0, 1'b0, 1, 1'b0);
      @(negedge clk);
      check("ferr_pulse", 32'(m_frame_err), 32'd1);
      check("ferr_valid", 32'(m_out_valid), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("ferr_width", 32'(m_frame_err), 32'd0);
      @(posedge clk); #1;

`ifdef SHIFT_DESER_PARITY_EN
      send_frame(8'hA6, 1'b1, 1'b1, 1, 1'b0);
      @(negedge clk);
      check("perr_pulse", 32'(m_parity_err), 32'd1);
      check("perr_valid", 32'(m_out_valid),  32'd0);
      @(posedge clk); #1;
      send_frame(8'hA6, 1'b1, 1'b0, 1, 1'b0);
      @(negedge clk);
      check("par_ok_data", 32'(m_out_data),   32'h0000_00A6);
      check("par_ok_perr", 32'(m_parity_err), 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
`endif

      // Held word, then reset in the middle of a frame.
      send_frame(8'h5A, 1'b1, 1'b0, 1, 1'b0);
      @(negedge clk);
      check("pre_rst_data", 32'(m_out_data), 32'h0000_005A);
      @(posedge clk); #1;
      tick(1'b0, 1);
      tick(1'b1, 1); tick(1'b1, 1); tick(1'b0, 1); tick(1'b0, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("midrst_busy",  32'(m_busy),      32'd0);
      check("midrst_valid", 32'(m_out_valid), 32'd0);
      check("midrst_ferr",  32'(m_frame_err), 32'd0);
      @(posedge clk); #1;
      send_frame(8'hC1, 1'b1, 1'b0, 1, 1'b0);
      @(negedge clk);
      check("post_rst_msb", 32'(m_out_data), 32'h0000_00C1);
      check("post_rst_lsb", 32'(l_out_data), 32'h0000_0083);
      @(posedge clk); #1;

      // Back-to-back frames, tick every cycle, consumer always ready.
      out_ready = 1'b1;
      send_frame(8'h81, 1'b1, 1'b0, 0, 1'b0);
      send_frame(8'h7E, 1'b1, 1'b0, 0, 1'b0);
      @(negedge clk);
      check("b2b_data",  32'(m_out_data),  32'h0000_007E);
      check("b2b_valid", 32'(m_out_valid), 32'd1);
      repeat (4) @(posedge clk);
      #1;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_shift_deser_rx
